// File: rtl/tpu_int_pkg.sv
// Shared definitions for the TPU timer interrupt receiver: FSM encoding, cause codes,
// default service vectors and the fixed-priority cause selector.
package tpu_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_TIMER = 2'b01;
    localparam logic [1:0] CAUSE_SW    = 2'b10;

    localparam logic [7:0] DEF_TIMER_VEC = 8'h04;
    localparam logic [7:0] DEF_SW_VEC    = 8'h08;

    // Timer always beats software when both are pending.
    function automatic logic [1:0] pick_cause(input logic tim_pend, input logic sw_pend);
        if (tim_pend) begin
            return CAUSE_TIMER;
        end
        if (sw_pend) begin
            return CAUSE_SW;
        end
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/tpu_int_edge.sv
// TPUINT rising-edge detector plus saturating count of edges that arrive while the
// timer cause is already pending and not being cleared in the same cycle.
module tpu_int_edge
    import tpu_int_pkg::*;
#(
    parameter int MISS_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_line,
    input  logic              i_pend_hold,
    output logic              o_rise,
    output logic [MISS_W-1:0] o_missed
);

    logic              r_prev;
    logic [MISS_W-1:0] r_missed;

    assign o_rise   = i_line & ~r_prev;
    assign o_missed = r_missed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= 1'b0;
            r_missed <= '0;
        end else begin
            r_prev <= i_line;
            if (o_rise && i_pend_hold && (r_missed != '1)) begin
                r_missed <= r_missed + MISS_W'(1);
            end
        end
    end

endmodule

// File: rtl/tpu_int_ctrl.sv
// TPU timer interrupt receiver: pending causes, IRQ/ACK/RETI handshake, vector/cause/stamp.
// Optional ACK watchdog enabled by defining TPU_INT_ACK_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no request outstanding; waits for GIE and a pending cause
// REQ     | IRQ asserted, waiting for CORE_ACK (GIE low withdraws it)
// SERVICE | handler running; cause latched, waits for RETI
module tpu_int_ctrl
    import tpu_int_pkg::*;
#(
    parameter int               VEC_W     = 8,
    parameter logic [VEC_W-1:0] TIMER_VEC = VEC_W'(DEF_TIMER_VEC),
    parameter logic [VEC_W-1:0] SW_VEC    = VEC_W'(DEF_SW_VEC),
    parameter int               MISS_W    = 4
`ifdef TPU_INT_ACK_TIMEOUT_EN
   ,parameter int               ACK_TIMEOUT = 64
`endif
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_tpuint,
    input  logic              i_swint,
    input  logic              i_gie,
    input  logic              i_core_ack,
    input  logic              i_reti,
    input  logic [6:0]        i_time,
    output logic              o_intflag,
    output logic              o_irq,
    output logic [VEC_W-1:0]  o_int_vector,
    output logic [1:0]        o_int_cause,
    output logic [6:0]        o_int_stamp,
    output logic              o_in_service,
    output logic [MISS_W-1:0] o_missed,
    output logic              o_ack_err
);

    int_state_t       r_state;
    logic             r_tim_pend;
    logic             r_sw_pend;
    logic             r_irq;
    logic             r_in_service;
    logic [1:0]       r_cause;
    logic [VEC_W-1:0] r_vector;
    logic [6:0]       r_stamp;

    logic             w_rise;
    logic             w_ack_take;
    logic [1:0]       w_pick;
    logic             w_tim_clr;
    logic             w_sw_clr;
    logic             w_pend_hold;

    assign w_ack_take  = (r_state == REQ) && i_core_ack;
    assign w_pick      = pick_cause(r_tim_pend, r_sw_pend);
    assign w_tim_clr   = w_ack_take && (w_pick == CAUSE_TIMER);
    assign w_sw_clr    = w_ack_take && (w_pick == CAUSE_SW);
    // An edge landing on the clearing cycle simply re-arms the cause; nothing is lost.
    assign w_pend_hold = r_tim_pend & ~w_tim_clr;

    tpu_int_edge #(
        .MISS_W (MISS_W)
    ) u_edge (
        .i_clk       (i_sys_clk),
        .i_rst       (i_rst),
        .i_line      (i_tpuint),
        .i_pend_hold (w_pend_hold),
        .o_rise      (w_rise),
        .o_missed    (o_missed)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_tim_pend <= 1'b0;
            r_sw_pend  <= 1'b0;
        end else begin
            if (w_rise) begin
                r_tim_pend <= 1'b1;
            end else if (w_tim_clr) begin
                r_tim_pend <= 1'b0;
            end
            if (i_swint) begin
                r_sw_pend <= 1'b1;
            end else if (w_sw_clr) begin
                r_sw_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_vector     <= '0;
            r_stamp      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_gie && (r_tim_pend || r_sw_pend)) begin
                        r_state <= REQ;
                        r_irq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_core_ack) begin
                        r_state      <= SERVICE;
                        r_irq        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_cause      <= w_pick;
                        r_vector     <= (w_pick == CAUSE_TIMER) ? TIMER_VEC : SW_VEC;
                        r_stamp      <= i_time;
                    end else if (!i_gie) begin
                        r_state <= IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (i_reti) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                        r_cause      <= CAUSE_NONE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_irq        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_cause      <= CAUSE_NONE;
                end
            endcase
        end
    end

`ifdef TPU_INT_ACK_TIMEOUT_EN
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_ack_cnt;
    logic             r_ack_err;

    // Counts REQ cycles; the flag fires on the ACK_TIMEOUT-th one and is sticky.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_ack_cnt <= '0;
            r_ack_err <= 1'b0;
        end else if (r_state != REQ) begin
            r_ack_cnt <= '0;
        end else if (r_ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            r_ack_err <= 1'b1;
        end else begin
            r_ack_cnt <= r_ack_cnt + CNT_W'(1);
        end
    end

    assign o_ack_err = r_ack_err;
`else
    assign o_ack_err = 1'b0;
`endif

    assign o_intflag    = r_tim_pend;
    assign o_irq        = r_irq;
    assign o_int_vector = r_vector;
    assign o_int_cause  = r_cause;
    assign o_int_stamp  = r_stamp;
    assign o_in_service = r_in_service;

endmodule

// File: tb/tb_tpu_int_ctrl.sv
// Bench for tpu_int_ctrl: directed vector table, hand-written corner sequences and a
// randomized run against a cycle-level behavioural model of the interrupt rules.
module tb_tpu_int_ctrl;
    import tpu_int_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tpuint, swint, gie, core_ack, reti;
    logic [6:0] tim;
    logic       intflag, irq, in_svc, ack_err;
    logic [7:0] vec;
    logic [1:0] cause;
    logic [6:0] stamp;
    logic [3:0] missed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tpu_int_ctrl dut (
        .i_sys_clk    (clk),
        .i_rst        (rst),
        .i_tpuint     (tpuint),
        .i_swint      (swint),
        .i_gie        (gie),
        .i_core_ack   (core_ack),
        .i_reti       (reti),
        .i_time       (tim),
        .o_intflag    (intflag),
        .o_irq        (irq),
        .o_int_vector (vec),
        .o_int_cause  (cause),
        .o_int_stamp  (stamp),
        .o_in_service (in_svc),
        .o_missed     (missed),
        .o_ack_err    (ack_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic s, input logic g, input logic a,
                         input logic r, input logic [6:0] tm);
        tpuint = t; swint = s; gie = g; core_ack = a; reti = r; tim = tm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 7'd0);
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       t, s, g, a, r;
        logic [6:0] tm;
        logic       e_irq, e_flag, e_svc;
        logic [1:0] e_cause;
        logic [7:0] e_vec;
        logic [6:0] e_stamp;
    } row_t;

    localparam int N_ROWS = 29;
    row_t tbl [N_ROWS];

    function automatic row_t mk(input logic t, s, g, a, r, input int tm,
                                input logic ei, ef, es, input int ec, ev, est);
        row_t x;
        x.t = t; x.s = s; x.g = g; x.a = a; x.r = r; x.tm = 7'(tm);
        x.e_irq = ei; x.e_flag = ef; x.e_svc = es;
        x.e_cause = 2'(ec); x.e_vec = 8'(ev); x.e_stamp = 7'(est);
        return x;
    endfunction

    // ---------------- behavioural model ----------------
    int m_prev, m_tp, m_sp, m_missed, m_phase, m_cause, m_vec, m_stamp;

    task automatic model_reset();
        m_prev = 0; m_tp = 0; m_sp = 0; m_missed = 0; m_phase = 0;
        m_cause = 0; m_vec = 0; m_stamp = 0;
    endtask

    task automatic model_step(input int r, t, s, g, a, rt, tm);
        int rise, taken;
        if (r != 0) begin
            model_reset();
            return;
        end
        rise  = (t != 0 && m_prev == 0) ? 1 : 0;
        taken = 0;
        if (m_phase == 1 && a != 0) taken = (m_tp != 0) ? 1 : ((m_sp != 0) ? 2 : 0);
        if (rise != 0 && m_tp != 0 && taken != 1 && m_missed < 15) m_missed++;
        case (m_phase)
            0: if (g != 0 && (m_tp != 0 || m_sp != 0)) m_phase = 1;
            1: begin
                if (a != 0) begin
                    m_phase = 2;
                    m_cause = taken;
                    m_vec   = (taken == 1) ? 4 : 8;
                    m_stamp = tm;
                end else if (g == 0) begin
                    m_phase = 0;
                end
            end
            default: if (rt != 0) begin
                m_phase = 0;
                m_cause = 0;
            end
        endcase
        if (rise != 0) m_tp = 1;
        else if (taken == 1) m_tp = 0;
        if (s != 0) m_sp = 1;
        else if (taken == 2) m_sp = 0;
        m_prev = t;
    endtask

    initial begin
        tbl[0]  = mk(1,0,1,0,0,10, 0,1,0,0,8'h00,0);
        tbl[1]  = mk(1,0,1,0,0,10, 1,1,0,0,8'h00,0);
        tbl[2]  = mk(1,0,1,0,0,10, 1,1,0,0,8'h00,0);
        tbl[3]  = mk(1,0,1,0,0,10, 1,1,0,0,8'h00,0);
        tbl[4]  = mk(1,0,1,1,0,10, 0,0,1,1,8'h04,10);
        tbl[5]  = mk(0,0,1,0,0,10, 0,0,1,1,8'h04,10);
        tbl[6]  = mk(0,0,1,0,1,10, 0,0,0,0,8'h04,10);
        tbl[7]  = mk(0,0,1,0,0,10, 0,0,0,0,8'h04,10);
        tbl[8]  = mk(1,1,1,0,0,20, 0,1,0,0,8'h04,10);
        tbl[9]  = mk(1,0,1,0,0,20, 1,1,0,0,8'h04,10);
        tbl[10] = mk(1,0,1,1,0,21, 0,0,1,1,8'h04,21);
        tbl[11] = mk(1,0,1,0,1,21, 0,0,0,0,8'h04,21);
        tbl[12] = mk(1,0,1,0,0,21, 1,0,0,0,8'h04,21);
        tbl[13] = mk(1,0,1,1,0,30, 0,0,1,2,8'h08,30);
        tbl[14] = mk(1,0,1,0,1,30, 0,0,0,0,8'h08,30);
        tbl[15] = mk(0,0,1,0,0,30, 0,0,0,0,8'h08,30);
        tbl[16] = mk(1,1,0,0,0,30, 0,1,0,0,8'h08,30);
        tbl[17] = mk(1,0,0,0,0,30, 0,1,0,0,8'h08,30);
        tbl[18] = mk(1,0,0,0,0,30, 0,1,0,0,8'h08,30);
        tbl[19] = mk(1,0,1,0,0,30, 1,1,0,0,8'h08,30);
        tbl[20] = mk(1,0,0,0,0,30, 0,1,0,0,8'h08,30);
        tbl[21] = mk(1,0,0,1,0,30, 0,1,0,0,8'h08,30);
        tbl[22] = mk(1,0,1,0,0,30, 1,1,0,0,8'h08,30);
        tbl[23] = mk(1,0,0,1,0,40, 0,0,1,1,8'h04,40);
        tbl[24] = mk(1,0,0,0,1,40, 0,0,0,0,8'h04,40);
        tbl[25] = mk(1,0,1,0,0,40, 1,0,0,0,8'h04,40);
        tbl[26] = mk(1,0,1,1,0,41, 0,0,1,2,8'h08,41);
        tbl[27] = mk(1,0,1,0,1,41, 0,0,0,0,8'h08,41);
        tbl[28] = mk(1,0,1,0,1,41, 0,0,0,0,8'h08,41);

        // reset state
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 7'd99);
        cycle();
        check("rst_irq", irq, 0);
        check("rst_intflag", intflag, 0);
        check("rst_in_service", in_svc, 0);
        check("rst_cause", cause, 0);
        check("rst_vector", vec, 0);
        check("rst_stamp", stamp, 0);
        check("rst_missed", missed, 0);
        check("rst_ack_err", ack_err, 0);
        do_reset();

        for (int i = 0; i < N_ROWS; i++) begin
            drive(tbl[i].t, tbl[i].s, tbl[i].g, tbl[i].a, tbl[i].r, tbl[i].tm);
            cycle();
            check($sformatf("row%0d_irq", i), irq, tbl[i].e_irq);
            check($sformatf("row%0d_intflag", i), intflag, tbl[i].e_flag);
            check($sformatf("row%0d_in_service", i), in_svc, tbl[i].e_svc);
            check($sformatf("row%0d_cause", i), cause, tbl[i].e_cause);
            check($sformatf("row%0d_vector", i), vec, tbl[i].e_vec);
            check($sformatf("row%0d_stamp", i), stamp, tbl[i].e_stamp);
            check($sformatf("row%0d_missed", i), missed, 0);
        end

        // missed-edge counter saturation, GIE low so nothing is served
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1, 0, 0, 0, 0, 7'd0);
            cycle();
            drive(0, 0, 0, 0, 0, 7'd0);
            cycle();
            if (i == 5) check("missed_after5", missed, 4);
        end
        check("missed_sat", missed, 15);
        check("missed_intflag", intflag, 1);
        check("missed_irq", irq, 0);

        // reset while in SERVICE, with a software cause still pending
        drive(0, 0, 1, 0, 0, 7'd5);
        cycle();
        check("svcrst_req_irq", irq, 1);
        drive(0, 1, 1, 1, 0, 7'd5);
        cycle();
        check("svcrst_in_service", in_svc, 1);
        check("svcrst_cause", cause, 1);
        drive(0, 0, 1, 0, 0, 7'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("svcrst_after_in_service", in_svc, 0);
        check("svcrst_after_irq", irq, 0);
        check("svcrst_after_intflag", intflag, 0);
        check("svcrst_after_missed", missed, 0);
        check("svcrst_after_cause", cause, 0);
        cycle();
        cycle();
        check("svcrst_sw_cleared_irq", irq, 0);

        // timer edge on the same cycle its pending bit is cleared: set wins
        do_reset();
        drive(1, 0, 1, 0, 0, 7'd3);
        cycle();
        drive(0, 0, 1, 0, 0, 7'd3);
        cycle();
        check("tclr_irq", irq, 1);
        drive(1, 0, 1, 1, 0, 7'd3);
        cycle();
        check("tclr_cause", cause, 1);
        check("tclr_intflag_kept", intflag, 1);
        drive(1, 0, 1, 0, 1, 7'd3);
        cycle();
        cycle();
        check("tclr_rereq_irq", irq, 1);

        // SWINT on the same cycle its pending bit is cleared: set wins
        do_reset();
        drive(0, 1, 1, 0, 0, 7'd6);
        cycle();
        drive(0, 0, 1, 0, 0, 7'd6);
        cycle();
        check("sclr_irq", irq, 1);
        drive(0, 1, 1, 1, 0, 7'd6);
        cycle();
        check("sclr_cause", cause, 2);
        drive(0, 0, 1, 0, 1, 7'd7);
        cycle();
        check("sclr_idle_irq", irq, 0);
        drive(0, 0, 1, 0, 0, 7'd7);
        cycle();
        check("sclr_rereq_irq", irq, 1);
        drive(0, 0, 1, 1, 0, 7'd8);
        cycle();
        check("sclr_cause2", cause, 2);
        check("sclr_vector2", vec, 8'h08);
        check("sclr_stamp2", stamp, 8);

`ifdef TPU_INT_ACK_TIMEOUT_EN
        do_reset();
        drive(1, 0, 1, 0, 0, 7'd0);
        cycle();
        cycle();
        check("to_irq_entry", irq, 1);
        for (int i = 0; i < 63; i++) cycle();
        check("to_not_yet", ack_err, 0);
        cycle();
        check("to_ack_err", ack_err, 1);
        check("to_irq_held", irq, 1);
        drive(1, 0, 1, 1, 0, 7'd0);
        cycle();
        check("to_in_service", in_svc, 1);
        check("to_ack_err_sticky", ack_err, 1);
`endif

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic r_i, t_i, s_i, g_i, a_i, rt_i;
            logic [6:0] tm_i;
            r_i  = ($urandom_range(0, 199) == 0);
            t_i  = ($urandom_range(0, 3) == 0) ? ~tpuint : tpuint;
            s_i  = ($urandom_range(0, 7) == 0);
            g_i  = ($urandom_range(0, 7) != 0);
            a_i  = ($urandom_range(0, 3) == 0);
            rt_i = ($urandom_range(0, 3) == 0);
            tm_i = 7'($urandom);
            rst = r_i;
            drive(t_i, s_i, g_i, a_i, rt_i, tm_i);
            cycle();
            model_step(int'(r_i), int'(t_i), int'(s_i), int'(g_i), int'(a_i), int'(rt_i), int'(tm_i));
            check("rnd_irq", irq, (m_phase == 1) ? 1 : 0);
            check("rnd_in_service", in_svc, (m_phase == 2) ? 1 : 0);
            check("rnd_intflag", intflag, m_tp);
            check("rnd_cause", cause, m_cause);
            check("rnd_vector", vec, m_vec);
            check("rnd_stamp", stamp, m_stamp);
            check("rnd_missed", missed, m_missed);
`ifndef TPU_INT_ACK_TIMEOUT_EN
            check("rnd_ack_err", ack_err, 0);
`endif
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_int_ctrl.md
Name: tpu_int_ctrl

Overview:
Receiving end of the TPU timer interrupt line. Takes the timer's TPUINT and a software request, and latches them as pending causes. Runs a request/acknowledge/return handshake with the TPU core and supplies the service vector, cause and timestamp. Drives INTFLAG back to the timer, which holds TPUINT asserted until the core acknowledges.

Parameters:
VEC_W, 8, width of INT_VECTOR
TIMER_VEC, 8'h04, vector issued for the timer cause
SW_VEC, 8'h08, vector issued for the software cause
MISS_W, 4, width of saturating missed-interrupt counter
ACK_TIMEOUT, 64, cycles in REQ before ACK_ERR (optional feature only)

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
TPUINT  in  1  timer interrupt line (level)
SWINT  in  1  software interrupt request, single-cycle pulse
GIE  in  1  global interrupt enable from core status register
CORE_ACK  in  1  core accepts request and branches to INT_VECTOR
RETI  in  1  core executed return-from-interrupt, single-cycle pulse
TIME  in  7  timer coarse time, sampled as timestamp
INTFLAG  out  1  timer cause pending, fed back to timer
IRQ  out  1  interrupt request to core
INT_VECTOR  out  VEC_W  vector of the accepted cause
INT_CAUSE  out  2  accepted cause: 2'b01 timer, 2'b10 software, 2'b00 none
INT_STAMP  out  7  TIME captured at acceptance
IN_SERVICE  out  1  handler active
MISSED  out  MISS_W  timer edges lost while already pending, saturating
ACK_ERR  out  1  sticky acknowledge-timeout flag (optional feature)

Behaviour:
- Reset: every output, pending bit, edge-detect register and counter is 0; FSM goes to IDLE.
- Timer pending:
  - Set on a TPUINT rising edge (registered prev-sample vs current).
  - A rising edge while already pending increments MISSED; MISSED saturates at 2^MISS_W-1.
  - INTFLAG equals the timer pending bit, registered.
- SW pending: set by SWINT. SWINT while already pending is ignored and not counted.
- FSM states IDLE, REQ, SERVICE:
  - IDLE -> REQ when GIE=1 and any pending bit is set. IRQ=1 on the cycle after entry, registered.
  - REQ -> IDLE if GIE=0 and CORE_ACK=0. IRQ drops and pending bits are kept.
  - REQ -> SERVICE on CORE_ACK.
    - Cause chosen by fixed priority, timer over software.
    - Capture INT_CAUSE, INT_VECTOR and INT_STAMP=TIME in the ACK cycle.
    - Clear the chosen pending bit; IRQ=0 and IN_SERVICE=1 from the next cycle.
    - CORE_ACK wins over a simultaneous GIE=0.
  - SERVICE -> IDLE on RETI. IN_SERVICE=0 and INT_CAUSE returns to 0. INT_VECTOR and INT_STAMP hold their last value.
  - IDLE lasts at least 1 cycle between RETI and the next IRQ. No nesting: pending bits accumulate during SERVICE.
- Ignored inputs: CORE_ACK outside REQ, RETI outside SERVICE.
- Simultaneous events:
  - A rising edge in the same cycle as the clear of the timer pending bit: set wins, and the cause stays pending.
  - SWINT in the same cycle as its clear: likewise set wins.
- RST mid-operation (any state): return to reset values on the next edge; the core must discard the handler.

Optional Feature:
TPU_INT_ACK_TIMEOUT_EN
- Defined:
  - A counter runs while in REQ and clears on leaving REQ.
  - Reaching ACK_TIMEOUT sets ACK_ERR, which stays set until RST.
  - The FSM stays in REQ; IRQ remains asserted.
- Undefined: no counter is built; ACK_ERR is tied to 0.

Decomposition:
- Package tpu_int_pkg holds:
  - enum int_state_t {IDLE, REQ, SERVICE}
  - cause constants CAUSE_NONE, CAUSE_TIMER, CAUSE_SW
  - default vector localparams
- One sub-module, tpu_int_edge: rising-edge detector plus saturating MISSED counter for TPUINT. Everything else is flat.

Test Plan:
- TPUINT rises at TIME=7'd10, GIE=1, CORE_ACK 3 cycles after IRQ -> INTFLAG=1 after 1 cycle; INT_VECTOR=8'h04, INT_CAUSE=01, INT_STAMP=10; INTFLAG=0 after ACK; RETI -> IDLE.
- SWINT and TPUINT edge in the same cycle -> timer served first. After RETI, IRQ reasserts after exactly 1 IDLE cycle with INT_VECTOR=8'h08, INT_CAUSE=10.
- GIE=0 with both pending -> IRQ stays 0. GIE=1 in REQ, then GIE=0 before ACK -> IRQ drops and both pending bits retained.
- 20 TPUINT rising edges while pending and no ACK, MISS_W=4 -> MISSED=15 (saturated).
- RST pulsed for 1 cycle in SERVICE -> next cycle IN_SERVICE=0, IRQ=0, INTFLAG=0, MISSED=0, INT_CAUSE=0.
- With TPU_INT_ACK_TIMEOUT_EN and no CORE_ACK for 64 cycles in REQ -> ACK_ERR=1 and remains 1 after a later ACK; without the macro ACK_ERR stays 0.
